// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle control FSM for the simple 16-bit CPU.
// Decodes IR (III XXX YYY) and drives register load enables, bus-source
// selects and the ALU operation over the IDLE/T1/T2/T3 sequence.
// Optional feature macro: CTRL_AND_EN (opcode 100 becomes bitwise AND).
// Outputs decode from state, ir, run and reset in the same cycle, because
// ir_in must follow run in IDLE and every output must read 0 while reset is high.
module cpu_control_unit (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [8:0] ir,
    output logic       ir_in,
    output logic [7:0] r_in,
    output logic [7:0] r_out,
    output logic       a_in,
    output logic       g_in,
    output logic       g_out,
    output logic       din_out,
    output logic [1:0] alu_op,
    output logic       done
);

    localparam int unsigned OP_W  = 3;
    localparam int unsigned REG_N = 8;

    localparam logic [OP_W-1:0] OP_MV  = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;
`ifdef CTRL_AND_EN
    localparam logic [OP_W-1:0] OP_AND = 3'b100;
`endif

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
`ifdef CTRL_AND_EN
    localparam logic [1:0] ALU_AND = 2'b10;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OP_W-1:0]  opcode;
    logic [REG_N-1:0] rx_sel;
    logic [REG_N-1:0] ry_sel;
    logic             is_alu_op;
    logic [1:0]       alu_code;

    // Instruction field decode: opcode and one-hot Rx/Ry selects
    assign opcode = ir[8:6];
    assign rx_sel = REG_N'(1) << ir[5:3];
    assign ry_sel = REG_N'(1) << ir[2:0];

    // Classify opcode as a three-step ALU instruction and pick its ALU code
    always_comb begin
        is_alu_op = 1'b0;
        alu_code  = ALU_ADD;
        case (opcode)
            OP_ADD: begin
                is_alu_op = 1'b1;
                alu_code  = ALU_ADD;
            end
            OP_SUB: begin
                is_alu_op = 1'b1;
                alu_code  = ALU_SUB;
            end
`ifdef CTRL_AND_EN
            OP_AND: begin
                is_alu_op = 1'b1;
                alu_code  = ALU_AND;
            end
`endif
            default: begin
                is_alu_op = 1'b0;
                alu_code  = ALU_ADD;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = run ? S_T1 : S_IDLE;
            S_T1:    state_d = is_alu_op ? S_T2 : S_IDLE;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Control output decode; everything forced to 0 while reset is high
    always_comb begin
        ir_in   = 1'b0;
        r_in    = '0;
        r_out   = '0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        alu_op  = ALU_ADD;
        done    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    ir_in = run;
                end
                S_T1: begin
                    if (opcode == OP_MV) begin
                        r_out = ry_sel;
                        r_in  = rx_sel;
                        done  = 1'b1;
                    end else if (opcode == OP_MVI) begin
                        din_out = 1'b1;
                        r_in    = rx_sel;
                        done    = 1'b1;
                    end else if (is_alu_op) begin
                        r_out = rx_sel;
                        a_in  = 1'b1;
                    end else begin
                        done = 1'b1;
                    end
                end
                S_T2: begin
                    r_out  = ry_sel;
                    g_in   = 1'b1;
                    alu_op = alu_code;
                end
                S_T3: begin
                    g_out = 1'b1;
                    r_in  = rx_sel;
                    done  = 1'b1;
                end
                default: begin
                    ir_in = 1'b0;
                end
            endcase
        end
    end

endmodule
